// File: rtl/des_key_schedule_dec.sv
// rtl/des_key_schedule_dec.sv - DES decrypt-direction key scheduler, K16 down to K1
// Applies PC-1 once, then right-rotates C/D so each handshake exposes the next lower subkey.
module des_key_schedule_dec (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] key,
   output logic        busy,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [3:0]  round,
   output logic        done
);

   localparam int pc1_tab [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int pc2_tab [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t      state, state_nxt;
   logic [27:0] c, d;
   logic [3:0]  rnd;
   logic        done_r;
   logic        handshake;
   logic        last;
   logic [3:0]  rnd_nxt;
   logic        rot_two;

   // FIPS bit n of a vector of width w lives at index w-n.
   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[55-i] = k[64-pc1_tab[i]];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         r[47-i] = cd[56-pc2_tab[i]];
      end
      return r;
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   assign handshake = (state == ISSUE) && subkey_ready;
   assign last      = (rnd == 4'd15);
   assign rnd_nxt   = rnd + 4'd1;
   // Indices 1, 8 and 15 undo the single-bit encrypt shifts; all others rotate by two.
   assign rot_two   = !((rnd_nxt == 4'd1) || (rnd_nxt == 4'd8) || (rnd_nxt == 4'd15));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ISSUE;
         ISSUE:   if (subkey_ready && last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c      <= '0;
         d      <= '0;
         rnd    <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= handshake && last;
         if (state == IDLE) begin
            if (start) begin
               {c, d} <= pc1(key);
               rnd    <= '0;
            end
         end else if (handshake) begin
            if (last) begin
               rnd <= '0;
            end else begin
               rnd <= rnd_nxt;
               c   <= rotr(c, rot_two);
               d   <= rotr(d, rot_two);
            end
         end
      end
   end

   assign busy         = (state == ISSUE);
   assign subkey_valid = (state == ISSUE);
   assign subkey       = subkey_valid ? pc2({c, d}) : 48'h0;
   assign round        = rnd;
   assign done         = done_r;

endmodule

// File: tb/tb_des_key_schedule_dec.sv
// tb/tb_des_key_schedule_dec.sv - directed bench for des_key_schedule_dec
// Expected keys come from a forward (encrypt-order) schedule model, reversed.
module tb_des_key_schedule_dec;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] key;
   logic        busy;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [47:0] subkey;
   logic [3:0]  round;
   logic        done;

   int errors;
   int checks;

   logic [47:0] exp_k [16];

   localparam int tpc1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int tpc2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int lshift [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_key_schedule_dec dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .key          (key),
      .busy         (busy),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .subkey       (subkey),
      .round        (round),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Forward FIPS schedule with left shifts; K(16-n) goes to issue index n.
   task automatic build_exp(input logic [63:0] k);
      logic [55:0] cd;
      logic [27:0] c0, d0;
      logic [47:0] ks;
      for (int i = 0; i < 56; i++) cd[55-i] = k[64-tpc1[i]];
      c0 = cd[55:28];
      d0 = cd[27:0];
      for (int r = 1; r <= 16; r++) begin
         for (int s = 0; s < lshift[r-1]; s++) begin
            c0 = {c0[26:0], c0[27]};
            d0 = {d0[26:0], d0[27]};
         end
         cd = {c0, d0};
         for (int i = 0; i < 48; i++) ks[47-i] = cd[56-tpc2[i]];
         exp_k[16-r] = ks;
      end
   endtask

   task automatic kick(input logic [63:0] k);
      key   = k;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
   endtask

   // Entered at a negedge showing round 0; returns at the negedge showing done.
   task automatic run_full(input string tag);
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (subkey_valid !== 1'b1 || round !== n[3:0] || subkey !== exp_k[n]) begin
            errors++;
            $display("FAIL %s key%0d: valid=%b round=%0d subkey=%h, required valid=1 round=%0d subkey=%h",
                     tag, n, subkey_valid, round, subkey, n, exp_k[n]);
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || subkey_valid !== 1'b0 || subkey !== 48'h0) begin
         errors++;
         $display("FAIL %s end: done=%b busy=%b valid=%b subkey=%h, required 1 0 0 0",
                  tag, done, busy, subkey_valid, subkey);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, subkey_valid, subkey, round, done} !== 55'h0) begin
         errors++;
         $display("FAIL reset: busy=%b valid=%b subkey=%h round=%0d done=%b, required all 0",
                  busy, subkey_valid, subkey, round, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_vectors;
      logic [47:0] seen [16];
      subkey_ready = 1'b1;
      build_exp(64'h133457799BBCDFF1);
      kick(64'h133457799BBCDFF1);
      for (int n = 0; n < 16; n++) begin
         seen[n] = subkey;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (seen[0] !== 48'hCB3D8B0E17F5) begin
         errors++; $display("FAIL vec_r0: got %h, required cb3d8b0e17f5", seen[0]);
      end
      checks++;
      if (seen[1] !== 48'hBF918D3D3F0A) begin
         errors++; $display("FAIL vec_r1: got %h, required bf918d3d3f0a", seen[1]);
      end
      checks++;
      if (seen[14] !== 48'h79AED9DBC9E5) begin
         errors++; $display("FAIL vec_r14: got %h, required 79aed9dbc9e5", seen[14]);
      end
      checks++;
      if (seen[15] !== 48'h1B02EFFC7072) begin
         errors++; $display("FAIL vec_r15: got %h, required 1b02effc7072", seen[15]);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL vec_done_t17: done=%b busy=%b, required 1 0", done, busy);
      end
      @(negedge clk);
      build_exp(64'h133457799BBCDFF1);
      kick(64'h133457799BBCDFF1);
      run_full("model");
      @(negedge clk);
   endtask

   task automatic test_stall;
      int          idx;
      int          cyc;
      logic        hs;
      logic        prev_stall;
      logic [47:0] prev_key;
      idx        = 0;
      cyc        = 0;
      prev_stall = 1'b0;
      prev_key   = '0;
      build_exp(64'h133457799BBCDFF1);
      subkey_ready = 1'b0;
      kick(64'h133457799BBCDFF1);
      while (idx < 16 && cyc < 300) begin
         checks++;
         if (subkey_valid !== 1'b1 || round !== idx[3:0] || subkey !== exp_k[idx] || done !== 1'b0) begin
            errors++;
            $display("FAIL stall key%0d: valid=%b round=%0d subkey=%h done=%b, required 1 %0d %h 0",
                     idx, subkey_valid, round, subkey, done, idx, exp_k[idx]);
         end
         if (prev_stall) begin
            checks++;
            if (subkey !== prev_key) begin
               errors++;
               $display("FAIL stall_hold: subkey=%h, required %h", subkey, prev_key);
            end
         end
         subkey_ready = ($urandom_range(0, 1) == 1);
         hs           = subkey_ready;
         prev_key     = subkey;
         prev_stall   = !hs;
         @(posedge clk);
         @(negedge clk);
         if (hs) idx++;
         cyc++;
      end
      checks++;
      if (idx != 16) begin
         errors++; $display("FAIL stall_timeout: issued %0d, required 16", idx);
      end
      checks++;
      if (done !== 1'b1 || subkey_valid !== 1'b0) begin
         errors++; $display("FAIL stall_done: done=%b valid=%b, required 1 0", done, subkey_valid);
      end
      subkey_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ignore_start;
      build_exp(64'h133457799BBCDFF1);
      subkey_ready = 1'b1;
      kick(64'h133457799BBCDFF1);
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (round !== n[3:0] || subkey !== exp_k[n]) begin
            errors++;
            $display("FAIL ignore key%0d: round=%0d subkey=%h, required %0d %h",
                     n, round, subkey, n, exp_k[n]);
         end
         if (n == 3) begin
            start = 1'b1;
            key   = 64'h0123456789ABCDEF;
         end
         if (n == 6) start = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL ignore_done: done=%b, required 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      build_exp(64'h133457799BBCDFF1);
      subkey_ready = 1'b1;
      kick(64'h133457799BBCDFF1);
      run_full("b2b_first");
      checks++;
      if (done !== 1'b1 || subkey_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_excl: done=%b valid=%b, required 1 0", done, subkey_valid);
      end
      build_exp(64'h0);
      kick(64'h0);
      run_full("b2b_zero");
      @(negedge clk);
   endtask

   task automatic test_mid_reset;
      build_exp(64'h133457799BBCDFF1);
      subkey_ready = 1'b1;
      kick(64'h133457799BBCDFF1);
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (round !== 4'd5) begin
         errors++; $display("FAIL midrst_pre: round=%0d, required 5", round);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, subkey_valid, subkey, round, done} !== 55'h0) begin
         errors++;
         $display("FAIL midrst_async: busy=%b valid=%b subkey=%h round=%0d done=%b, required all 0",
                  busy, subkey_valid, subkey, round, done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_nodone: done=%b busy=%b, required 0 0", done, busy);
         end
      end
      kick(64'h133457799BBCDFF1);
      run_full("midrst_restart");
      @(negedge clk);
   endtask

   task automatic test_parity;
      build_exp(64'h133457799BBCDFF1);
      subkey_ready = 1'b1;
      kick(64'h123456789ABCDEF0);
      run_full("parity");
      @(negedge clk);
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b0;
      start        = 1'b0;
      key          = '0;
      subkey_ready = 1'b0;
      @(negedge clk);
      test_reset;
      test_vectors;
      test_stall;
      test_ignore_start;
      test_back_to_back;
      test_mid_reset;
      test_parity;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/des_key_schedule_dec.md
# des_key_schedule_dec

Sequential DES key scheduler for the decryption direction. Takes a 64-bit DES key, applies PC-1 once, then issues the 16 48-bit round subkeys in reverse order (K16 first, K1 last), one per accepted valid/ready handshake, using right rotations of the C/D halves. It sits between the key register and the round datapath of the DES decrypt path, complementing the encrypt-direction permutation and key logic.

## Interface

Parameters: none. All widths are fixed by FIPS 46-3.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  begin a schedule; sampled only when `busy`=0
- `key`  in  64  DES key; FIPS bit 1 = `key[63]`, parity bits ignored
- `busy`  out  1  schedule in progress
- `subkey_valid`  out  1  `subkey`/`round` hold a valid key
- `subkey_ready`  in  1  consumer accepts current subkey
- `subkey`  out  48  PC-2(C,D); FIPS bit 1 = `subkey[47]`
- `round`  out  4  issue index 0..15; index n carries K(16-n)
- `done`  out  1  one-cycle pulse after the final handshake

## Operation

- Tables: PC-1 and PC-2 are exactly FIPS 46-3; C = PC-1 bits 1..28, D = bits 29..56.
- States:
  - IDLE: `busy`=0, `subkey_valid`=0.
  - On `start`=1, latch C,D = PC-1(`key`) with no rotation, set `round`=0, and go to ISSUE.
- ISSUE behaviour:
  - `busy`=1, `subkey_valid`=1, and `subkey` = PC-2(C,D), combinational from registers.
  - `subkey` is stable while valid and not accepted.
  - Handshake = `subkey_valid` & `subkey_ready` at a rising edge.
  - On handshake with `round`<15: `round`+1, and C and D each rotate right by R(next round).
  - On handshake with `round`=15: go to IDLE, and `done`=1 for the next cycle.
- Right-rotate amounts R for issue index 1..15, in order: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Index 0 has no rotation.
  - Total rotation is 27, so C,D never wrap back to C0,D0 within a schedule.
- `start` is ignored while `busy`=1. `key` is only sampled at the start edge and may change afterwards.
- `subkey_ready` is ignored while `subkey_valid`=0.

## Timing

- Reset (asynchronous assert, any state): IDLE, and all outputs are 0 (`busy`, `subkey_valid`, `subkey`, `round`, `done`). C and D are cleared.
  - A mid-schedule reset abandons the schedule with no `done`.
  - `subkey` is 0 whenever `subkey_valid`=0; the output is gated.
- Latency: `start` sampled at edge T, so `subkey_valid`=1 and `round`=0 from T+1.
- With `subkey_ready` held high, keys issue at T+1..T+16, one per cycle.
  - At T+17: `done`=1, `busy`=0, `subkey_valid`=0.
- Back-to-back: `start`=1 during the `done` cycle is accepted, because IDLE is already entered, and the next key 0 appears at T+18.
- `done` and `subkey_valid` are never high together.
- Stalls: `subkey_ready`=0 holds `round`, `subkey` and C,D unchanged for any number of cycles.

## Test plan

- Reset mid-ISSUE at `round`=5 → all outputs 0 immediately. A subsequent `start` restarts from `round`=0 with no `done` from the aborted run.
- `key`=0x133457799BBCDFF1, `start` pulse, ready held high:
  - `round` 0 `subkey`=0xCB3D8B0E17F5
  - `round` 1 = 0xBF918D3D3F0A
  - `round` 14 = 0x79AED9DBC9E5
  - `round` 15 = 0x1B02EFFC7072
  - `done` at T+17
- Same key, `subkey_ready` toggling randomly → identical 16-key sequence. `subkey` is stable across every stalled cycle, and `done` comes exactly one cycle after the 16th handshake.
- `start` and a different `key` asserted while `busy` → ignored. The sequence continues unchanged and `round` counts 0..15 once.
- `start` asserted in the `done` cycle with `key`=0 → accepted. `round` 0 `subkey`=0x000000000000 at the next cycle, and all 16 subkeys are 0.
- Parity-only difference: `key`=0x133457799BBCDFF1 versus 0x123456789ABCDEF0 with parity bits altered to match → identical subkeys for equal non-parity bits.
